// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// The exe stage launches an operation by holding start_i. The unit stalls
// the pipeline through stallreq_o until the result comes back on result_o.
// ready_o pulses for one cycle when result_o is valid.
// Signed operands are reduced to magnitudes at launch. The signs are put
// back when the result is written.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset, highest priority
//   start_i     divide request (level, held while stalled)
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   dividend_i  rs1 value (sampled with start)
//   divisor_i   rs2 value (sampled with start)
//   annul_i     pipeline flush, aborts any operation in flight
//   result_o    registered quotient or remainder
//   ready_o     one-cycle pulse, result_o valid
//   stallreq_o  exe stall request to pipe_ctrl
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              inSigned;
    logic              aNeg;
    logic              bNeg;
    logic [DATA_W-1:0] absA;
    logic [DATA_W-1:0] absB;
    logic [DATA_W:0]   shifted;
    logic              geDiv;
    logic [DATA_W-1:0] remNext;
    logic [DATA_W-1:0] quotNext;
    logic [DATA_W-1:0] quotFinal;
    logic [DATA_W-1:0] remFinal;

    // State register with synchronous reset that clears every internal register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
        end
    end

    // Operand magnitudes at launch and one restoring step for CALC.
    // quot_q starts out holding the dividend magnitude. Its MSB feeds the
    // partial remainder while quotient bits fill in from the LSB.
    always_comb begin
        inSigned  = ~op_i[0];
        aNeg      = inSigned & dividend_i[DATA_W-1];
        bNeg      = inSigned & divisor_i[DATA_W-1];
        absA      = aNeg ? (~dividend_i + 1'b1) : dividend_i;
        absB      = bNeg ? (~divisor_i + 1'b1) : divisor_i;
        shifted   = {rem_q, quot_q[DATA_W-1]};
        geDiv     = (shifted >= {1'b0, divisor_q});
        remNext   = geDiv ? (shifted[DATA_W-1:0] - divisor_q) : shifted[DATA_W-1:0];
        quotNext  = {quot_q[DATA_W-2:0], geDiv};
        quotFinal = (~op_q[0] & qneg_q) ? (~quotNext + 1'b1) : quotNext;
        remFinal  = (~op_q[0] & rneg_q) ? (~remNext + 1'b1) : remNext;
    end

    // Next-state logic. Annul sends the unit back to IDLE from any state and
    // leaves result_q alone, so a flushed operation produces no visible result.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;

        if (annul_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_d      = op_i;
                        divisor_d = absB;
                        quot_d    = absA;
                        rem_d     = '0;
                        cnt_d     = '0;
                        qneg_d    = aNeg ^ bNeg;
                        rneg_d    = aNeg;
                        if (divisor_i == '0) begin
                            // Divide by zero: the RISC-V defined result, with no iterations.
                            result_d = op_i[1] ? dividend_i : '1;
                            state_d  = DONE;
                        end else if (inSigned && dividend_i == MinNeg && divisor_i == '1) begin
                            // Signed overflow: the quotient saturates to MinNeg and the remainder is zero.
                            result_d = op_i[1] ? '0 : MinNeg;
                            state_d  = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    quot_d = quotNext;
                    rem_d  = remNext;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        result_d = op_q[1] ? remFinal : quotFinal;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    // start_i is ignored here so that a held request cannot relaunch.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == DONE);
    assign stallreq_o = ((state_q == IDLE) & start_i & ~annul_i) | (state_q == CALC);

endmodule
